// File: rtl/pixel_batch_writer.sv
// Packs an RGB pixel stream into multi-pixel line-buffer words with
// write address, ping-pong block select and frame geometry measurement.
module pixel_batch_writer #(
    parameter  int MAX_WIDTH      = 1920,
    parameter  int MAX_HEIGHT     = 1080,
    parameter  int CHANNEL_COUNT  = 3,
    parameter  int BATCH_SIZE     = 4,
    parameter  int ADDRESS_NUMBER = 140,
    parameter  int BLOCK_COUNT    = 2,
    localparam int AW = (ADDRESS_NUMBER > 1) ? $clog2(ADDRESS_NUMBER) : 1,
    localparam int BW = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1,
    localparam int WW = $clog2(MAX_WIDTH + 1),
    localparam int HW = $clog2(MAX_HEIGHT + 1),
    localparam int DW = 8 * BATCH_SIZE * CHANNEL_COUNT
) (
    input  logic                       I_rgb_clk,
    input  logic                       I_rst_n,
    input  logic                       I_rgb_de,
    input  logic                       I_rgb_hs,
    input  logic                       I_rgb_vs,
    input  logic [8*CHANNEL_COUNT-1:0] I_rgb_color,
    output logic [DW-1:0]              O_data_flat,
    output logic [AW-1:0]              O_address,
    output logic [BW-1:0]              O_block_select,
    output logic                       O_write_enable,
    output logic                       O_row_done,
    output logic                       O_overflow,
    output logic [WW-1:0]              O_image_width,
    output logic [HW-1:0]              O_image_height,
    output logic                       O_image_valid
);

    localparam int CW = $clog2(BATCH_SIZE + 1);
    localparam int AC = $clog2(ADDRESS_NUMBER + 1);

    logic            r_vs_d;
    logic            r_in_line;
    logic [CW-1:0]   r_k;
    logic [DW-1:0]   r_pack;
    logic [AC-1:0]   r_addr;
    logic            r_discard;
    logic [BW-1:0]   r_blk;
    logic [WW-1:0]   r_wcnt;
    logic [HW-1:0]   r_hcnt;
    logic [WW-1:0]   r_prev_w;
    logic [HW-1:0]   r_prev_h;
    logic            r_we;
    logic [DW-1:0]   r_data;
    logic [AW-1:0]   r_addr_o;
    logic [BW-1:0]   r_blk_o;
    logic            r_row_done;
    logic            r_ovf;
    logic [WW-1:0]   r_width;
    logic [HW-1:0]   r_height;
    logic            r_valid;

    logic            w_vs_rise;
    logic            w_end;
    logic            w_pix;
    logic [CW-1:0]   w_cnt;
    logic            w_issue;
    logic            w_room;
    logic            w_wr;
    logic            w_ovf_set;
    logic            w_rd_now;
    logic [WW-1:0]   w_wnext;
    logic [HW-1:0]   w_hnext;
    logic [WW-1:0]   w_w_frame;
    logic [BW-1:0]   w_blk_inc;
    logic [DW-1:0]   w_pack;

    // A VS rise during DE closes the line in the same cycle as the frame.
    assign w_vs_rise = I_rgb_vs & ~r_vs_d;
    assign w_end     = (r_in_line & ~I_rgb_de) | (w_vs_rise & I_rgb_de);
    assign w_pix     = I_rgb_de & ~r_discard;
    assign w_cnt     = r_k + CW'(w_pix);
    assign w_issue   = (w_cnt == CW'(BATCH_SIZE)) | (w_end & (w_cnt != '0));
    assign w_room    = r_addr < AC'(ADDRESS_NUMBER);
    assign w_wr      = w_issue & w_room;
    assign w_ovf_set = w_issue & ~w_room;
    // Line ended on a batch boundary: its last write is already on the bus.
    assign w_rd_now  = w_end & ~w_issue & r_we;

    assign w_wnext = (I_rgb_de && r_wcnt != WW'(MAX_WIDTH)) ?
                     r_wcnt + WW'(1) : r_wcnt;
    assign w_hnext = (w_end && r_hcnt != HW'(MAX_HEIGHT)) ?
                     r_hcnt + HW'(1) : r_hcnt;
    assign w_w_frame = w_end ? w_wnext : r_width;
    assign w_blk_inc = (r_blk == BW'(BLOCK_COUNT - 1)) ?
                       '0 : r_blk + BW'(1);

    always_comb begin
        w_pack = r_pack;
        if (w_pix) begin
            for (int c = 0; c < CHANNEL_COUNT; c++) begin
                for (int k = 0; k < BATCH_SIZE; k++) begin
                    if (r_k == CW'(k))
                        w_pack[8*(c*BATCH_SIZE+k) +: 8] =
                            I_rgb_color[8*c +: 8];
                end
            end
        end
    end

    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_vs_d    <= 1'b0;
            r_in_line <= 1'b0;
            r_k       <= '0;
            r_pack    <= '0;
            r_addr    <= '0;
            r_discard <= 1'b0;
        end else begin
            r_vs_d    <= I_rgb_vs;
            r_in_line <= I_rgb_de & ~w_end;
            if (w_issue || w_end) begin
                r_k    <= '0;
                r_pack <= '0;
            end else begin
                r_k    <= w_cnt;
                r_pack <= w_pack;
            end
            if (w_end)
                r_addr <= '0;
            else if (w_wr)
                r_addr <= r_addr + AC'(1);
            if (w_end)
                r_discard <= 1'b0;
            else if (w_ovf_set)
                r_discard <= 1'b1;
        end
    end

    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_we       <= 1'b0;
            r_data     <= '0;
            r_addr_o   <= '0;
            r_blk_o    <= '0;
            r_row_done <= 1'b0;
            r_blk      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_we       <= w_wr;
            r_row_done <= w_end & ~w_rd_now;
            if (w_wr) begin
                r_data   <= w_pack;
                r_addr_o <= r_addr[AW-1:0];
                r_blk_o  <= r_blk;
            end
            if (w_vs_rise)
                r_blk <= '0;
            else if (w_end)
                r_blk <= w_blk_inc;
            if (w_vs_rise)
                r_ovf <= 1'b0;
            else if (w_ovf_set)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_wcnt   <= '0;
            r_hcnt   <= '0;
            r_width  <= '0;
            r_height <= '0;
            r_prev_w <= '0;
            r_prev_h <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_wcnt <= w_end ? '0 : w_wnext;
            if (w_end)
                r_width <= w_wnext;
            if (w_vs_rise) begin
                r_height <= w_hnext;
                r_hcnt   <= '0;
                r_prev_w <= w_w_frame;
                r_prev_h <= w_hnext;
                r_valid  <= (w_w_frame == r_prev_w) &&
                            (w_hnext == r_prev_h) &&
                            (w_w_frame != '0) && (w_hnext != '0);
            end else begin
                r_hcnt <= w_hnext;
                if (w_end && w_wnext != r_width)
                    r_valid <= 1'b0;
            end
        end
    end

    assign O_data_flat    = r_data;
    assign O_address      = r_addr_o;
    assign O_block_select = r_blk_o;
    assign O_write_enable = r_we;
    assign O_row_done     = r_row_done | w_rd_now;
    assign O_overflow     = r_ovf;
    assign O_image_width  = r_width;
    assign O_image_height = r_height;
    assign O_image_valid  = r_valid;

endmodule

// File: tb/tb_pixel_batch_writer.sv
// Bench for pixel_batch_writer: line-level model checked every cycle
// plus literal expectations from hand-worked pixel lines.
module tb_pixel_batch_writer;

    localparam int CH = 3;
    localparam int B  = 4;
    localparam int AN = 2;
    localparam int BC = 2;
    localparam int MW = 1920;
    localparam int MH = 1080;
    localparam int DW = 96;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        de = 1'b0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic [23:0] color = '0;

    logic [DW-1:0] o_data;
    logic [0:0]    o_addr;
    logic [0:0]    o_blk;
    logic          o_we;
    logic          o_rd;
    logic          o_ovf;
    logic [10:0]   o_w;
    logic [10:0]   o_h;
    logic          o_valid;

    pixel_batch_writer #(
        .MAX_WIDTH(MW), .MAX_HEIGHT(MH), .CHANNEL_COUNT(CH),
        .BATCH_SIZE(B), .ADDRESS_NUMBER(AN), .BLOCK_COUNT(BC)
    ) dut (
        .I_rgb_clk(clk), .I_rst_n(rst_n), .I_rgb_de(de),
        .I_rgb_hs(hs), .I_rgb_vs(vs), .I_rgb_color(color),
        .O_data_flat(o_data), .O_address(o_addr),
        .O_block_select(o_blk), .O_write_enable(o_we),
        .O_row_done(o_rd), .O_overflow(o_ovf),
        .O_image_width(o_w), .O_image_height(o_h),
        .O_image_valid(o_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] data;
        logic [0:0]    addr;
        logic [0:0]    blk;
        logic          rd;
        logic          ovf;
        logic [10:0]   w;
        logic [10:0]   h;
        logic          valid;
    } exp_t;

    exp_t cur = '0;
    exp_t nxt = '0;

    logic [23:0] q[$];
    int  waddr, blk, wcnt, lines, pw, ph;
    bit  discard, in_line, pvs;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] wr_log[$];
    int addr_log[$];
    int blk_log[$];
    int rdw;

    function automatic void chk(string n, logic [127:0] a, logic [127:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endfunction

    function automatic logic [23:0] px(int k);
        logic [7:0] r = 8'(k);
        logic [7:0] g = 8'(k + 16);
        logic [7:0] b = 8'(k + 32);
        return {b, g, r};
    endfunction

    function automatic logic [DW-1:0] pack();
        logic [DW-1:0] r = '0;
        for (int i = 0; i < q.size(); i++)
            for (int c = 0; c < CH; c++)
                r[8*(c*B+i) +: 8] = q[i][8*c +: 8];
        return r;
    endfunction

    task automatic compare();
        @(negedge clk);
        chk("we", o_we, cur.we);
        if (cur.we) begin
            chk("data", o_data, cur.data);
            chk("addr", o_addr, cur.addr);
            chk("blk", o_blk, cur.blk);
        end
        chk("row_done", o_rd, cur.rd);
        chk("overflow", o_ovf, cur.ovf);
        chk("width", o_w, cur.w);
        chk("height", o_h, cur.h);
        chk("valid", o_valid, cur.valid);
        if (o_we) begin
            wr_log.push_back(o_data);
            addr_log.push_back(int'(o_addr));
            blk_log.push_back(int'(o_blk));
            if (o_rd) rdw++;
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        addr_log.delete();
        blk_log.delete();
        rdw = 0;
    endtask

    task automatic model_reset();
        cur = '0;
        nxt = '0;
        q.delete();
        waddr = 0; blk = 0; wcnt = 0; lines = 0; pw = 0; ph = 0;
        discard = 0; in_line = 0; pvs = 0;
    endtask

    task automatic step(input bit d, input bit v, input logic [23:0] col);
        bit vr, pix, endl, iss;
        @(posedge clk);
        #1;
        de = d; vs = v; color = col;
        cur = nxt;
        nxt.we = 1'b0;
        nxt.rd = 1'b0;
        vr   = v & !pvs;
        pix  = d & !discard;
        endl = (in_line & !d) | (vr & d);
        iss  = 0;
        if (pix) q.push_back(col);
        if (q.size() == B || (endl && q.size() > 0)) begin
            iss = 1;
            if (waddr < AN) begin
                nxt.we   = 1'b1;
                nxt.data = pack();
                nxt.addr = 1'(waddr);
                nxt.blk  = 1'(blk);
                waddr++;
            end else begin
                nxt.ovf = 1'b1;
                discard = 1;
            end
            q.delete();
        end
        if (d && wcnt < MW) wcnt++;
        if (endl) begin
            if (!iss && cur.we) cur.rd = 1'b1;
            else nxt.rd = 1'b1;
            if (wcnt != int'(nxt.w)) nxt.valid = 1'b0;
            nxt.w = 11'(wcnt);
            wcnt = 0;
            if (lines < MH) lines++;
            waddr = 0;
            discard = 0;
            blk = (blk + 1) % BC;
        end
        if (vr) begin
            nxt.h = 11'(lines);
            nxt.valid = (int'(nxt.w) == pw) && (lines == ph) &&
                        (nxt.w != 0) && (lines != 0);
            pw = int'(nxt.w);
            ph = lines;
            lines = 0;
            blk = 0;
            nxt.ovf = 1'b0;
        end
        in_line = d & !endl;
        pvs = v;
        compare();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; de = 1'b0; vs = 1'b0; color = '0;
        model_reset();
        compare();
        repeat (2) begin
            @(posedge clk);
            compare();
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare();
    endtask

    task automatic line(input int n, input int gap);
        for (int k = 0; k < n; k++) step(1, 0, px(k));
        for (int g = 0; g < gap; g++) step(0, 0, '0);
    endtask

    task automatic vs_pulse();
        step(0, 1, '0);
        step(0, 0, '0);
        step(0, 0, '0);
    endtask

    task automatic frame(input int w);
        for (int l = 0; l < 4; l++) line(w, 4);
        vs_pulse();
    endtask

    initial begin
        model_reset();
        compare();
        do_reset();
        chk("rst_we", o_we, 0);
        chk("rst_width", o_w, 0);
        chk("rst_valid", o_valid, 0);
        vs_pulse();

        clear_logs();
        line(8, 3);
        chk("l8_nwr", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("l8_word0", wr_log[0], 96'h23222120_13121110_03020100);
            chk("l8_addr0", addr_log[0], 0);
            chk("l8_addr1", addr_log[1], 1);
        end
        chk("l8_rd_with_wr", rdw, 1);
        chk("l8_width", o_w, 8);

        clear_logs();
        line(6, 3);
        chk("l6_nwr", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("l6_word1", wr_log[1], 96'h00002524_00001514_00000504);
            chk("l6_addr1", addr_log[1], 1);
            chk("l6_blk", blk_log[1], 1);
        end
        chk("l6_rd_with_wr", rdw, 1);

        clear_logs();
        line(12, 3);
        chk("l12_nwr", wr_log.size(), 2);
        chk("l12_ovf", o_ovf, 1);

        clear_logs();
        line(8, 1);
        line(4, 3);
        chk("b2b_nwr", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            chk("b2b_addr", addr_log[2], 0);
            chk("b2b_blk", blk_log[2], 0);
        end
        chk("b2b_ovf", o_ovf, 1);
        vs_pulse();
        chk("vs_ovf_clr", o_ovf, 0);
        chk("vs_height", o_h, 5);

        frame(640);
        chk("f1_valid", o_valid, 0);
        frame(640);
        chk("f2_valid", o_valid, 1);
        chk("f2_width", o_w, 640);
        chk("f2_height", o_h, 4);
        line(320, 4);
        chk("f3_valid_drop", o_valid, 0);
        for (int l = 0; l < 3; l++) line(320, 4);

        clear_logs();
        step(1, 0, px(0));
        step(1, 0, px(1));
        step(1, 1, px(2));
        step(0, 1, '0);
        step(0, 0, '0);
        step(0, 0, '0);
        chk("vsde_nwr", wr_log.size(), 1);
        if (wr_log.size() == 1)
            chk("vsde_word", wr_log[0], 96'h00222120_00121110_00020100);
        chk("vsde_rd_with_wr", rdw, 1);
        chk("vsde_height", o_h, 5);
        chk("vsde_width", o_w, 3);

        clear_logs();
        step(1, 0, px(0));
        step(1, 0, px(1));
        do_reset();
        step(0, 0, '0);
        step(0, 0, '0);
        chk("rst_mid_nwr", wr_log.size(), 0);
        chk("rst_mid_width", o_w, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_batch_writer.md
# pixel_batch_writer

Parametrised successor of the HDMI input stage. Packs an N-channel 8-bit RGB pixel stream into BATCH_SIZE-pixel words, flushes partial batches at line end with zero padding, and generates write address and ping-pong block select for the line buffer. It also measures frame geometry with a two-frame stability check and flags address overflow. Sits between the HDMI receiver and the line buffer write port, in the rgb clock domain.

## Interface
- MAX_WIDTH, 1920, largest supported active width in pixels
- MAX_HEIGHT, 1080, largest supported active height in lines
- CHANNEL_COUNT, 3, colour channels per pixel (1..4)
- BATCH_SIZE, 4, pixels packed per write word (1..8)
- ADDRESS_NUMBER, 140, write addresses per block
- BLOCK_COUNT, 2, line-buffer blocks cycled per line (1..4)

Ports:
- I_rgb_clk  in  1  pixel clock; sole clock
- I_rst_n  in  1  asynchronous active-low reset
- I_rgb_de  in  1  data enable, active high
- I_rgb_hs  in  1  hsync, active high (informational only)
- I_rgb_vs  in  1  vsync, active high
- I_rgb_color  in  8*CHANNEL_COUNT  pixel; channel c at bits [8c+7:8c]
- O_data_flat  out  8*BATCH_SIZE*CHANNEL_COUNT  packed word
- O_address  out  $clog2(ADDRESS_NUMBER)  write address within block
- O_block_select  out  $clog2(BLOCK_COUNT), min 1  target block
- O_write_enable  out  1  one-cycle write strobe
- O_row_done  out  1  one-cycle pulse after a line's last write
- O_overflow  out  1  sticky: line exceeded ADDRESS_NUMBER words
- O_image_width  out  $clog2(MAX_WIDTH+1)  last measured active width
- O_image_height  out  $clog2(MAX_HEIGHT+1)  last measured active height
- O_image_valid  out  1  geometry stable and nonzero

## Operation
- Packing: each DE-high cycle writes channel c of pixel k (k = 0..BATCH_SIZE-1 within batch) to O_data_flat bits [8*(c*BATCH_SIZE+k)+7 : 8*(c*BATCH_SIZE+k)]. Channel-major, pixel 0 least significant.
- Full batch: capture of pixel BATCH_SIZE-1 issues a write; pixel counter returns to 0.
- Flush: on DE falling edge with 0 < k < BATCH_SIZE, issue one write; unfilled pixel slots are 0x00. If k = 0 (line ended on a batch boundary), no extra write.
- Address: starts at 0 each line; increments after every issued write. When a write would need address ≥ ADDRESS_NUMBER, the write is suppressed, O_overflow set; remaining pixels of that line discarded.
- O_overflow cleared only at VS rising edge or reset.
- Block select: 0 at VS rising edge; increments at each DE falling edge, wraps BLOCK_COUNT-1 → 0. BLOCK_COUNT = 1: constant 0.
- O_row_done: pulses at each DE falling edge, including zero-write (overflowed) lines.
- Width: DE-high cycles per line, saturating at MAX_WIDTH; O_image_width updated at DE falling edge.
- Height: lines (DE falling edges) since last VS rising edge, saturating at MAX_HEIGHT; latched to O_image_height at VS rising edge, then counter cleared.
- Stability: at VS rising edge, O_image_valid = 1 iff the width and height just latched equal the previous frame's values and both are nonzero; otherwise 0. Width changing mid-frame clears O_image_valid immediately.
- VS rising while DE high: treated as DE fall first (flush, row_done, block advance), then frame end in the same cycle. Block select ends at 0.
- I_rgb_hs is ignored.

## Timing
- Reset: all outputs 0; internal counters, stored previous geometry and packing register 0.
- Write latency: O_write_enable, O_data_flat, O_address, O_block_select are registered, valid the cycle after the last pixel of the batch (or the cycle after DE fall for a flush); stable only while O_write_enable = 1.
- O_row_done asserts the same cycle as a line's final write (flush or full), or the cycle after DE fall if no write.
- DE returning high the cycle after falling: no pixel lost; new line starts at address 0, k = 0.
- Reset mid-line: pending partial batch discarded, no write.

## Test plan
- CHANNEL_COUNT=3, BATCH_SIZE=4, line of 8 pixels with values R=k, G=0x10+k, B=0x20+k -> 2 writes, addresses 0,1; word 0 = 0x23222120_13121110_03020100; row_done with second write.
- 6-pixel line -> writes at addr 0,1; second word pixel slots 2,3 zero in every channel; row_done on flush cycle.
- ADDRESS_NUMBER=2, 12-pixel line -> 2 writes, O_overflow high from third-batch cycle until next VS rise; next line writes normally from addr 0.
- BLOCK_COUNT=2, 3 lines -> block select 0,1,0; VS rise -> 0.
- Two frames of 640x4 -> O_image_valid 0 after first VS, 1 after second, width 640, height 4; third frame 320x4 -> valid drops at first 320-pixel line end.
- VS rising while DE high with 3 pending pixels -> flush write and row_done same cycle, height counts that line.
